// File: rtl/gf163_pkg.sv
// rtl/gf163_pkg.sv - shared constants and types for the GF(2^163) multiplier loader
// Purpose: field/word geometry, reduction constant, FSM state encoding, word index type.
// Ports: none (package).
package gf163_pkg;

    localparam int W  = 32;
    localparam int M  = 163;
    localparam int NW = 6;

    // Low byte of the reduction polynomial x^163 + x^7 + x^6 + x^3 + 1.
    localparam logic [7:0] POLY_LOW = 8'hC9;

    localparam int IDX_W = $clog2(NW);
    typedef logic [IDX_W-1:0] idx_t;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        LAUNCH  = 2'd1,
        DRAIN   = 2'd2
    } state_t;

endpackage

// File: rtl/gf163_mult_loader_if.sv
// rtl/gf163_mult_loader_if.sv - host-side operand and result streams
// Purpose: bundles the word-wide operand input stream and result output stream.
// Ports (signals): in_valid/in_ready/in_data (operands to loader),
//                  out_valid/out_ready/out_data (result from loader).
// Modports: master = host side, slave = loader side.
interface gf163_mult_loader_if
    import gf163_pkg::*;
#(
    parameter int W = gf163_pkg::W
) ();

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );

endinterface

// File: rtl/gf163_word_buf.sv
// rtl/gf163_word_buf.sv - M-bit register with word-indexed write/read and full-width load
// Purpose: holds one field element; written a word at a time or loaded whole,
//          read a word at a time. Bits above M-1 never exist, so the top word
//          is masked on both write and read.
// Ports: clk, rst (async, active-high); wr_en/wr_idx/wr_data word write;
//        load_en/load_data full-width load (wins over word write);
//        rd_idx/rd_data word read; vec full contents.
module gf163_word_buf
    import gf163_pkg::*;
#(
    parameter int W  = gf163_pkg::W,
    parameter int M  = gf163_pkg::M,
    parameter int NW = gf163_pkg::NW
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_en,
    input  idx_t         wr_idx,
    input  logic [W-1:0] wr_data,
    input  logic         load_en,
    input  logic [M-1:0] load_data,
    input  idx_t         rd_idx,
    output logic [W-1:0] rd_data,
    output logic [M-1:0] vec
);

    localparam int PW = NW * W;

    // Zero-padded view: padding bits read as 0 and are dropped on write-back.
    logic [PW-1:0] pad;
    logic [PW-1:0] pad_wr;

    assign pad = PW'(vec);

    always_comb begin
        pad_wr                  = pad;
        pad_wr[wr_idx*W +: W]   = wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vec <= '0;
        end else if (load_en) begin
            vec <= load_data;
        end else if (wr_en) begin
            vec <= pad_wr[M-1:0];
        end
    end

    assign rd_data = pad[rd_idx*W +: W];

endmodule

// File: rtl/gf163_mult_loader.sv
// rtl/gf163_mult_loader.sv - word-serial front/back end for the GF(2^163) multiplier
// Purpose: collects A then B (least-significant word first) from the host stream,
//          holds mul_start while the multiplier runs, captures mul_z on mul_done,
//          and streams the result back a word at a time. A LAUNCH that sees no
//          mul_done within TIMEOUT cycles sets the sticky err flag and returns
//          to COLLECT.
// Ports: clk, rst (async, active-high); host (operand/result streams);
//        mul_a, mul_b, mul_start, mul_z, mul_done (multiplier side);
//        busy (not in COLLECT), err (sticky timeout), err_clr (sync clear).
module gf163_mult_loader
    import gf163_pkg::*;
#(
    parameter int W       = gf163_pkg::W,
    parameter int M       = gf163_pkg::M,
    parameter int NW      = gf163_pkg::NW,
    parameter int TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    gf163_mult_loader_if.slave   host,
    output logic [M-1:0]         mul_a,
    output logic [M-1:0]         mul_b,
    output logic                 mul_start,
    input  logic [M-1:0]         mul_z,
    input  logic                 mul_done,
    output logic                 busy,
    output logic                 err,
    input  logic                 err_clr
);

    localparam int            TW       = $clog2(TIMEOUT + 1);
    localparam logic [3:0]    LAST_IN  = 4'(2 * NW - 1);
    localparam logic [3:0]    NW_CNT   = 4'(NW);
    localparam idx_t          LAST_OUT = idx_t'(NW - 1);
    localparam logic [TW-1:0] TMAX     = TW'(TIMEOUT);

    state_t        state;
    state_t        state_nx;
    logic [3:0]    in_cnt;
    idx_t          out_cnt;
    logic [TW-1:0] launch_cnt;

    logic in_hs;
    logic out_hs;
    logic done_hit;
    logic timeout_hit;
    logic a_wr;
    logic b_wr;
    idx_t wr_idx;

    // All handshake outputs come straight from the state register.
    assign host.in_ready  = (state == COLLECT);
    assign host.out_valid = (state == DRAIN);
    assign mul_start      = (state == LAUNCH);
    assign busy           = (state != COLLECT);

    assign in_hs       = host.in_valid && host.in_ready;
    assign out_hs      = host.out_valid && host.out_ready;
    assign done_hit    = (state == LAUNCH) && mul_done;
    // A done arriving on the final allowed cycle still counts as success.
    assign timeout_hit = (state == LAUNCH) && !mul_done && (launch_cnt == TMAX);

    // Words 0..NW-1 go to A, NW..2*NW-1 go to B.
    always_comb begin
        a_wr   = 1'b0;
        b_wr   = 1'b0;
        wr_idx = idx_t'(in_cnt);
        if (in_cnt < NW_CNT) begin
            a_wr   = in_hs;
        end else begin
            b_wr   = in_hs;
            wr_idx = idx_t'(in_cnt - NW_CNT);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= COLLECT;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            COLLECT: begin
                if (in_hs && (in_cnt == LAST_IN)) begin
                    state_nx = LAUNCH;
                end
            end
            LAUNCH: begin
                if (done_hit) begin
                    state_nx = DRAIN;
                end else if (timeout_hit) begin
                    state_nx = COLLECT;
                end
            end
            DRAIN: begin
                if (out_hs && (out_cnt == LAST_OUT)) begin
                    state_nx = COLLECT;
                end
            end
            default: state_nx = COLLECT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_cnt     <= '0;
            out_cnt    <= '0;
            launch_cnt <= '0;
        end else begin
            if (in_hs) begin
                in_cnt <= (in_cnt == LAST_IN) ? 4'd0 : in_cnt + 4'd1;
            end
            if (out_hs) begin
                out_cnt <= (out_cnt == LAST_OUT) ? idx_t'(0) : out_cnt + idx_t'(1);
            end
            // Counts cycles spent in LAUNCH; zero on entry.
            if ((state == LAUNCH) && (state_nx == LAUNCH)) begin
                launch_cnt <= launch_cnt + TW'(1);
            end else begin
                launch_cnt <= '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= 1'b0;
        end else if (timeout_hit) begin
            err <= 1'b1;
        end else if (err_clr) begin
            err <= 1'b0;
        end
    end

    gf163_word_buf #(.W(W), .M(M), .NW(NW)) u_buf_a (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (a_wr),
        .wr_idx    (wr_idx),
        .wr_data   (host.in_data),
        .load_en   (1'b0),
        .load_data ('0),
        .rd_idx    (idx_t'(0)),
        .rd_data   (),
        .vec       (mul_a)
    );

    gf163_word_buf #(.W(W), .M(M), .NW(NW)) u_buf_b (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (b_wr),
        .wr_idx    (wr_idx),
        .wr_data   (host.in_data),
        .load_en   (1'b0),
        .load_data ('0),
        .rd_idx    (idx_t'(0)),
        .rd_data   (),
        .vec       (mul_b)
    );

    gf163_word_buf #(.W(W), .M(M), .NW(NW)) u_buf_z (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (1'b0),
        .wr_idx    (idx_t'(0)),
        .wr_data   ('0),
        .load_en   (done_hit),
        .load_data (mul_z),
        .rd_idx    (out_cnt),
        .rd_data   (host.out_data),
        .vec       ()
    );

endmodule

// File: doc/gf163_mult_loader.md
# gf163_mult_loader

Word-serial front/back end for the GF(2^163) interleaved multiplier (reduction polynomial x^163+x^7+x^6+x^3+1). It collects operands A and B as 32-bit words from the host-side stream and presents them as 163-bit vectors to the multiplier. It holds the multiplier's start through the whole operation and captures the single-cycle result. It then returns Z to the host as 32-bit words with valid/ready backpressure.

## Interface
- `W`, default 32: word width.
- `M`, default 163: field degree and operand width.
- `NW`, default 6: words per operand, ceil(M/W).
- `TIMEOUT`, default 255: maximum LAUNCH cycles to wait for `mul_done`.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `in_valid` in 1, `in_ready` out 1, `in_data` in W: operand stream.
- `out_valid` out 1, `out_ready` in 1, `out_data` out W: result stream.
- `mul_a`, `mul_b` out M: operands to the multiplier.
- `mul_start` out 1: multiplier start, held high for the whole operation.
- `mul_z` in M: multiplier result; valid only while `mul_done` is high.
- `mul_done` in 1: single-cycle completion from the multiplier.
- `busy` out 1: high when state is not COLLECT.
- `err` out 1: sticky timeout flag.
- `err_clr` in 1: synchronous clear for `err`.

## Operation
States: COLLECT, LAUNCH, DRAIN.

**COLLECT**
- `in_ready`=1.
- Each handshake writes the next word. Order is A word0..5, then B word0..5, least-significant word first.
- Word k maps to bits [32k+31:32k]. Word 5 uses bits [2:0] only; bits [31:3] are discarded.
- On acceptance of the 12th word, go to LAUNCH and reset the word counter.

**LAUNCH**
- `mul_start`=1. `mul_a`/`mul_b` are stable.
- A cycle counter increments every cycle.
- `mul_done`=1: latch `mul_z` into the result register and go to DRAIN.
- Counter reaches TIMEOUT with no `mul_done`: set `err`, discard operands, go to COLLECT.

**DRAIN**
- `out_valid`=1. `out_data` is result word k, with word 5 bits [31:3]=0.
- k advances on each `out_valid && out_ready`.
- After word 5 transfers, go to COLLECT.

**General rules**
- `mul_done` outside LAUNCH is ignored.
- `in_data` outside COLLECT is not accepted.
- `err_clr` and a timeout in the same cycle: the timeout wins, so `err` stays 1.
- `mul_a`/`mul_b` change only in COLLECT.
- All outputs are derived from registered state; there is no combinational path from `in_valid` to `in_ready`, or from `out_ready` to `out_valid`.

## Timing
**Reset values** (state COLLECT, counters 0):
- `in_ready`=1
- `out_valid`=0
- `mul_start`=0
- `busy`=0
- `err`=0
- `mul_a`=`mul_b`=0
- `out_data`=0

**Launch**
- 12th word accepted at edge t: `mul_start`=1 and `busy`=1 from cycle t+1.
- Multiplier latency is unknown to this block; it is nominally ~167 cycles.

**Completion**
- `mul_done` sampled high at edge d: result is latched at d.
- From cycle d+1: `mul_start`=0 and `out_valid`=1 with word 0.
- `mul_start` never remains high after `mul_done`.

**Output stream**
- One word per cycle under continuous `out_ready`: DRAIN lasts 6 cycles.
- `in_ready`=1 in the cycle after the last output transfer.

**Timeout**
- `err`=1 at edge t+1+TIMEOUT.
- `in_ready`=1 in the next cycle.

**Reset mid-operation**
- All state is cleared immediately (asynchronous).
- Partial operands and the result are discarded, and `mul_start` drops.

## Structure
- Package `gf163_pkg` holds:
  - `M`, `W`, `NW`;
  - the reduction constant `POLY_LOW` = 8'hC9;
  - the state enum (COLLECT/LAUNCH/DRAIN);
  - the word-index width.
- One sub-module, `gf163_word_buf`, with M bits, W-bit word write/read by index and masking of the top word. It is instanced three times: A, B and result.
- The FSM and counters live in the top module.

## Test plan
1. A=1, B=1 (words 1,0,0,0,0,0 each); behavioural multiplier model -> output words 1,0,0,0,0,0; `err`=0.
2. A=x^162 (word5=0x4, other words 0), B=x (word0=0x2) -> output word0=0x000000C9, words 1–5=0.
3. Word 5 of A sent as 0xFFFFFFFC with A otherwise 0, B=1 -> output word5=0x4; bits [31:3] are never nonzero.
4. Random `in_valid` gaps and `out_ready` toggling at 50% -> identical result to the streaming case; `mul_start` high from the cycle after the 12th word until the cycle of `mul_done`.
5. `mul_done` tied 0, TIMEOUT=16 -> `err`=1 exactly 17 cycles after the 12th acceptance, `in_ready`=1 next cycle; `err_clr` -> `err`=0.
6. `rst` asserted during DRAIN after 2 words -> `out_valid`=0 and `mul_start`=0 immediately, `in_ready`=1; a new operation completes correctly.
